// File: rtl/stream_transpose_pkg.sv
// Shared types and helpers for the element-serial matrix transpose block.
package stream_transpose_pkg;

    typedef enum logic {
        LOAD  = 1'b0,
        DRAIN = 1'b1
    } state_e;

    localparam logic MODE_PASS      = 1'b0;
    localparam logic MODE_TRANSPOSE = 1'b1;

    // Bits needed to hold 0..n-1, never less than one bit.
    function automatic int unsigned width(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/stream_transpose_if.sv
// Element-serial in/out streams plus mode and busy for stream_transpose.
interface stream_transpose_if #(
    parameter int unsigned nBits = 2
);
    logic             mode;
    logic             in_valid;
    logic             in_ready;
    logic [nBits-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [nBits-1:0] out_data;
    logic             out_last;
    logic             busy;

    modport master (
        output mode, in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_last, busy
    );

    modport slave (
        input  mode, in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_last, busy
    );
endinterface

// File: rtl/stream_transpose_idx2_counter.sv
// Nested (outer, inner) index counter; swap exchanges the two limits at run time.
module idx2_counter
    import stream_transpose_pkg::*;
#(
    parameter int unsigned INNER = 2,
    parameter int unsigned OUTER = 2,
    parameter int unsigned W     = width((INNER > OUTER) ? INNER : OUTER)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         step,
    input  logic         swap,
    output logic [W-1:0] inner,
    output logic [W-1:0] outer,
    output logic         last_c
);

    logic [W-1:0] inner_max;
    logic [W-1:0] outer_max;

    assign inner_max = swap ? W'(OUTER - 1) : W'(INNER - 1);
    assign outer_max = swap ? W'(INNER - 1) : W'(OUTER - 1);
    assign last_c    = (inner == inner_max) && (outer == outer_max);

    // Inner index runs fastest; outer wraps to zero after its limit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inner <= '0;
            outer <= '0;
        end else if (clr) begin
            inner <= '0;
            outer <= '0;
        end else if (step) begin
            if (inner == inner_max) begin
                inner <= '0;
                outer <= (outer == outer_max) ? '0 : outer + W'(1);
            end else begin
                inner <= inner + W'(1);
            end
        end
    end

endmodule

// File: rtl/stream_transpose.sv
// Buffers an M x N matrix arriving row-major, then drains it transposed (or unchanged).
module stream_transpose
    import stream_transpose_pkg::*;
#(
    parameter int unsigned M         = 2,
    parameter int unsigned N         = 2,
    parameter int unsigned nBits     = 2,
    parameter bit          BYPASS_EN = 1'b1
) (
    input logic               clk,
    input logic               rst_n,
    stream_transpose_if.slave bus
);

    localparam int unsigned DEPTH = M * N;
    localparam int unsigned CW    = width((M > N) ? M : N);
    localparam int unsigned AW    = width(DEPTH);

    state_e           state, state_nxt;
    logic             mode_q, mode_nxt;
    logic             busy_q, busy_nxt;
    logic             in_ready_c, out_valid_c;
    logic             in_step, in_clr, out_step, out_clr;

    logic [CW-1:0]    wr_c, wr_r, rd_i, rd_o;
    logic             wr_last_c, rd_last_c;
    logic [AW-1:0]    waddr, raddr;
    logic [nBits-1:0] mem [DEPTH];

    idx2_counter #(.INNER(N), .OUTER(M), .W(CW)) u_wr_cnt (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (in_clr),
        .step   (in_step),
        .swap   (1'b0),
        .inner  (wr_c),
        .outer  (wr_r),
        .last_c (wr_last_c)
    );

    // Transpose walks rows fastest (inner=M); pass-through swaps back to inner=N.
    idx2_counter #(.INNER(M), .OUTER(N), .W(CW)) u_rd_cnt (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (out_clr),
        .step   (out_step),
        .swap   (mode_q == MODE_PASS),
        .inner  (rd_i),
        .outer  (rd_o),
        .last_c (rd_last_c)
    );

    assign waddr = AW'(32'(wr_r) * N + 32'(wr_c));
    assign raddr = (mode_q == MODE_TRANSPOSE) ? AW'(32'(rd_i) * N + 32'(rd_o))
                                              : AW'(32'(rd_o) * N + 32'(rd_i));

    always_ff @(posedge clk) begin
        if (in_step) mem[waddr] <= bus.in_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= LOAD;
            mode_q <= MODE_TRANSPOSE;
            busy_q <= 1'b0;
        end else begin
            state  <= state_nxt;
            mode_q <= mode_nxt;
            busy_q <= busy_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        mode_nxt    = mode_q;
        busy_nxt    = busy_q;
        in_ready_c  = 1'b0;
        out_valid_c = 1'b0;
        in_step     = 1'b0;
        in_clr      = 1'b0;
        out_step    = 1'b0;
        out_clr     = 1'b0;
        unique case (state)
            LOAD: begin
                in_ready_c = 1'b1;
                if (bus.in_valid) begin
                    in_step  = 1'b1;
                    busy_nxt = 1'b1;
                    // Mode is captured only on the first element of a matrix.
                    if (wr_r == '0 && wr_c == '0)
                        mode_nxt = BYPASS_EN ? bus.mode : MODE_TRANSPOSE;
                    if (wr_last_c) begin
                        state_nxt = DRAIN;
                        in_clr    = 1'b1;
                        out_clr   = 1'b1;
                    end
                end
            end
            DRAIN: begin
                out_valid_c = 1'b1;
                if (bus.out_ready) begin
                    out_step = 1'b1;
                    if (rd_last_c) begin
                        state_nxt = LOAD;
                        busy_nxt  = 1'b0;
                        out_clr   = 1'b1;
                    end
                end
            end
            default: state_nxt = LOAD;
        endcase
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = out_valid_c;
    assign bus.out_data  = mem[raddr];
    assign bus.out_last  = out_valid_c & rd_last_c;
    // The accepting cycle of the first element already counts as busy.
    assign bus.busy      = busy_q | (in_ready_c & bus.in_valid);

endmodule

// File: tb/tb_stream_transpose.sv
// Randomised bench for stream_transpose across four shapes, checked against a queue model.
module tb_stream_transpose;

    localparam int unsigned W = 8;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       mode, in_valid, out_ready;
    logic [7:0] in_data;
    logic [1:0] sel;
    int         n_pass, n_checks;

    int cfg_m   [4] = '{2, 1, 1, 3};
    int cfg_n   [4] = '{3, 4, 1, 2};
    bit cfg_byp [4] = '{1'b1, 1'b1, 1'b1, 1'b0};

    always #5 clk = ~clk;

    stream_transpose_if #(.nBits(W)) b0 ();
    stream_transpose_if #(.nBits(W)) b1 ();
    stream_transpose_if #(.nBits(W)) b2 ();
    stream_transpose_if #(.nBits(W)) b3 ();

    stream_transpose #(.M(2), .N(3), .nBits(W), .BYPASS_EN(1'b1)) dut0 (.clk(clk), .rst_n(rst_n), .bus(b0.slave));
    stream_transpose #(.M(1), .N(4), .nBits(W), .BYPASS_EN(1'b1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(b1.slave));
    stream_transpose #(.M(1), .N(1), .nBits(W), .BYPASS_EN(1'b1)) dut2 (.clk(clk), .rst_n(rst_n), .bus(b2.slave));
    stream_transpose #(.M(3), .N(2), .nBits(W), .BYPASS_EN(1'b0)) dut3 (.clk(clk), .rst_n(rst_n), .bus(b3.slave));

    // Only the selected instance sees handshakes; the rest sit idle in LOAD.
    assign b0.mode = mode; assign b0.in_data = in_data;
    assign b1.mode = mode; assign b1.in_data = in_data;
    assign b2.mode = mode; assign b2.in_data = in_data;
    assign b3.mode = mode; assign b3.in_data = in_data;
    assign b0.in_valid = in_valid & (sel == 2'd0); assign b0.out_ready = out_ready & (sel == 2'd0);
    assign b1.in_valid = in_valid & (sel == 2'd1); assign b1.out_ready = out_ready & (sel == 2'd1);
    assign b2.in_valid = in_valid & (sel == 2'd2); assign b2.out_ready = out_ready & (sel == 2'd2);
    assign b3.in_valid = in_valid & (sel == 2'd3); assign b3.out_ready = out_ready & (sel == 2'd3);

    logic [3:0] v_in_ready, v_out_valid, v_out_last, v_busy;
    logic [7:0] v_out_data [4];
    assign v_in_ready[0] = b0.in_ready; assign v_out_valid[0] = b0.out_valid;
    assign v_out_last[0] = b0.out_last; assign v_busy[0] = b0.busy; assign v_out_data[0] = b0.out_data;
    assign v_in_ready[1] = b1.in_ready; assign v_out_valid[1] = b1.out_valid;
    assign v_out_last[1] = b1.out_last; assign v_busy[1] = b1.busy; assign v_out_data[1] = b1.out_data;
    assign v_in_ready[2] = b2.in_ready; assign v_out_valid[2] = b2.out_valid;
    assign v_out_last[2] = b2.out_last; assign v_busy[2] = b2.busy; assign v_out_data[2] = b2.out_data;
    assign v_in_ready[3] = b3.in_ready; assign v_out_valid[3] = b3.out_valid;
    assign v_out_last[3] = b3.out_last; assign v_busy[3] = b3.busy; assign v_out_data[3] = b3.out_data;

    logic       o_in_ready, o_out_valid, o_out_last, o_busy;
    logic [7:0] o_out_data;
    assign o_in_ready  = v_in_ready[sel];
    assign o_out_valid = v_out_valid[sel];
    assign o_out_last  = v_out_last[sel];
    assign o_busy      = v_busy[sel];
    assign o_out_data  = v_out_data[sel];

    task automatic chk(input string tag, input int got, input int exp_v);
        n_checks++;
        if (got === exp_v) n_pass++;
        else $display("FAIL %s sel=%0d got=%0d expected=%0d t=%0t", tag, sel, got, exp_v, $time);
    endtask

    task automatic do_reset();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        rst_n     = 1'b0;
        #1;
        chk("rst_out_valid", 32'(o_out_valid), 0);
        chk("rst_busy", 32'(o_busy), 0);
        chk("rst_out_last", 32'(o_out_last), 0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("rst_in_ready", 32'(o_in_ready), 1);
        chk("rst_out_valid2", 32'(o_out_valid), 0);
        @(posedge clk); #1;
    endtask

    // base < 0 selects random element values; abort_* >= 0 resets after that many accepts.
    task automatic run_matrix(input int s, input logic md, input bit rnd, input int base,
                              input int abort_in, input int abort_out, input bit hold_last);
        int         m, n, total, k, idx, guard, busy_cnt;
        bit         tmode, held;
        logic [7:0] data [$];
        logic [7:0] expq [$];
        m     = cfg_m[s];
        n     = cfg_n[s];
        total = m * n;
        sel   = 2'(s);
        data  = {};
        expq  = {};
        for (int i = 0; i < total; i++)
            data.push_back((base < 0) ? 8'($urandom_range(0, 255)) : 8'(base + i));
        tmode = cfg_byp[s] ? md : 1'b1;
        if (tmode) begin
            for (int j = 0; j < n; j++)
                for (int i = 0; i < m; i++) expq.push_back(data[i * n + j]);
        end else begin
            expq = data;
        end

        k = 0; guard = 0; busy_cnt = 0;
        while (k < total && guard < 50 * total) begin
            in_valid = !(rnd && $urandom_range(0, 3) == 0);
            in_data  = data[k];
            mode     = (k == 0) ? md : 1'($urandom);
            @(negedge clk);
            chk("load_in_ready", 32'(o_in_ready), 1);
            chk("load_out_valid", 32'(o_out_valid), 0);
            if (o_busy) busy_cnt++;
            if (in_valid && o_in_ready) k++;
            guard++;
            @(posedge clk); #1;
            if (k == abort_in) begin
                do_reset();
                return;
            end
        end
        in_valid = 1'b0;
        if (k < total) chk("load_timeout", k, total);

        idx = 0; guard = 0; held = 1'b0;
        while (idx < total && guard < 50 * total) begin
            out_ready = !(rnd && $urandom_range(0, 2) == 0);
            if (hold_last && idx == total - 1 && !held) begin
                out_ready = 1'b0;
                held      = 1'b1;
            end
            @(negedge clk);
            chk("out_valid", 32'(o_out_valid), 1);
            chk("drain_in_ready", 32'(o_in_ready), 0);
            chk("out_data", 32'(o_out_data), 32'(expq[idx]));
            chk("out_last", 32'(o_out_last), (idx == total - 1) ? 1 : 0);
            if (o_busy) busy_cnt++;
            if (out_ready && o_out_valid) idx++;
            guard++;
            @(posedge clk); #1;
            if (idx == abort_out) begin
                do_reset();
                return;
            end
        end
        out_ready = 1'b0;
        if (idx < total) chk("drain_timeout", idx, total);
        @(negedge clk);
        chk("idle_out_valid", 32'(o_out_valid), 0);
        chk("idle_busy", 32'(o_busy), 0);
        if (!rnd) chk("busy_cycles", busy_cnt, 2 * total);
        @(posedge clk); #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1);
    end

    initial begin
        n_pass = 0; n_checks = 0;
        rst_n = 1'b0; mode = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_data = '0; sel = 2'd0;
        repeat (2) @(posedge clk);
        #1;
        chk("por_out_valid", 32'(o_out_valid), 0);
        chk("por_busy", 32'(o_busy), 0);
        chk("por_out_last", 32'(o_out_last), 0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("por_in_ready", 32'(o_in_ready), 1);
        @(posedge clk); #1;

        run_matrix(0, 1'b1, 1'b0, 1, -1, -1, 1'b0);
        run_matrix(0, 1'b0, 1'b0, 1, -1, -1, 1'b0);
        run_matrix(0, 1'b1, 1'b0, 7, -1, -1, 1'b0);
        run_matrix(0, 1'b1, 1'b1, 1, -1, -1, 1'b1);
        repeat (6) run_matrix(0, 1'($urandom), 1'b1, -1, -1, -1, 1'b1);

        run_matrix(0, 1'b1, 1'b0, 20, 4, -1, 1'b0);
        run_matrix(0, 1'b1, 1'b0, 30, -1, -1, 1'b0);
        run_matrix(0, 1'b1, 1'b0, 40, -1, 2, 1'b0);
        run_matrix(0, 1'b1, 1'b0, 50, -1, -1, 1'b0);

        run_matrix(1, 1'b1, 1'b0, 1, -1, -1, 1'b0);
        run_matrix(2, 1'b1, 1'b0, 9, -1, -1, 1'b0);
        run_matrix(3, 1'b0, 1'b0, 1, -1, -1, 1'b0);
        for (int s = 1; s < 4; s++)
            repeat (3) run_matrix(s, 1'($urandom), 1'b1, -1, -1, -1, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
